door_motion_sequencer: RTL and testbench

Supervisory controller for the garage-door motor pair. It takes two requesters, a wall button and a remote, merges their requests, and sequences UP/DN motor drive. It adds a travel-timeout watchdog, obstruction auto-reverse with a motor dead-time, and a latched fault state. It sits between the user-input pins and the motor drivers.

---
 rtl/door_motion_sequencer.sv | 134 +++++++++++++
 tb/tb_door_motion_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/door_motion_sequencer.sv
// Garage-door supervisor: merges wall/remote presses, sequences UP/DN drive with
// travel watchdog, obstruction reverse via dead-time, latched fault. Optional: DOOR_AUTO_CLOSE_EN.
module door_motion_sequencer #(
  parameter int CNT_W             = 8,
  parameter int DEAD_TIME         = 4,
  parameter int TRAVEL_TIMEOUT    = 200,
  parameter int AUTO_CLOSE_CYCLES = 150
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Wall_Btn,
  input  logic       Remote_Btn,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Obstruct,
  input  logic       Fault_Clr,
  output logic       UP_Motor,
  output logic       DN_Motor,
  output logic       Fault,
  output logic [2:0] Door_State
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_MV_UP = 3'b001,
    ST_MV_DN = 3'b010,
    ST_DEAD  = 3'b011,
    ST_FAULT = 3'b100
  } state_t;

`ifdef DOOR_AUTO_CLOSE_EN
  localparam bit AC_EN = 1'b1;
`else
  localparam bit AC_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] AC_LAST      = CNT_W'(AUTO_CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_up_q, last_up_d;
  logic             req_q, req_d;
  logic             up_motor_q, up_motor_d;
  logic             dn_motor_q, dn_motor_d;
  logic             fault_q, fault_d;

  logic req, act, both_lim, cnt_run;

  assign req      = Wall_Btn | Remote_Btn;
  assign act      = req & ~req_q;
  assign both_lim = UP_Max & DN_Max;

  always_comb begin
    state_d    = state_q;
    last_up_d  = last_up_q;
    cnt_run    = 1'b0;
    req_d      = req;
    unique case (state_q)
      ST_IDLE: begin
        if (both_lim)                        state_d = ST_FAULT;
        else if (act && DN_Max)              state_d = ST_MV_UP;
        else if (act && UP_Max)              state_d = ST_MV_DN;
        else if (act)                        state_d = last_up_q ? ST_MV_DN : ST_MV_UP;
        else if (AC_EN && UP_Max && !Obstruct) begin
          if (cnt_q == AC_LAST) state_d = ST_MV_DN;
          else                  cnt_run = 1'b1;
        end
      end
      ST_MV_UP: begin
        if (both_lim)                  state_d = ST_FAULT;
        else if (UP_Max || act)        state_d = ST_IDLE;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
        else                           cnt_run = 1'b1;
      end
      ST_MV_DN: begin
        if (both_lim)                  state_d = ST_FAULT;
        else if (DN_Max)               state_d = ST_IDLE;
        else if (Obstruct)             state_d = ST_DEAD;
        else if (act)                  state_d = ST_IDLE;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
        else                           cnt_run = 1'b1;
      end
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) state_d = ST_MV_UP;
        else                    cnt_run = 1'b1;
      end
      ST_FAULT: begin
        if (Fault_Clr && !both_lim) state_d = ST_IDLE;
      end
      default: state_d = ST_FAULT;
    endcase

    // Any exit from travel (limit, stop, obstruction, watchdog) records the travel direction.
    if (state_q == ST_MV_UP && state_d != ST_MV_UP) last_up_d = 1'b1;
    if (state_q == ST_MV_DN && state_d != ST_MV_DN) last_up_d = 1'b0;

    if (state_d != state_q || !cnt_run) cnt_d = '0;
    else if (cnt_q == CNT_MAX)          cnt_d = cnt_q;
    else                                cnt_d = cnt_q + 1'b1;

    up_motor_d = (state_d == ST_MV_UP);
    dn_motor_d = (state_d == ST_MV_DN);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_up_q  <= 1'b0;
      req_q      <= 1'b0;
      up_motor_q <= 1'b0;
      dn_motor_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_up_q  <= last_up_d;
      req_q      <= req_d;
      up_motor_q <= up_motor_d;
      dn_motor_q <= dn_motor_d;
      fault_q    <= fault_d;
    end
  end

  assign UP_Motor   = up_motor_q;
  assign DN_Motor   = dn_motor_q;
  assign Fault      = fault_q;
  assign Door_State = state_q;

endmodule

// File: tb/tb_door_motion_sequencer.sv
// Scoreboard bench for door_motion_sequencer: stimulus queues the expected state per edge,
// a monitor pops and checks state code plus motor/fault outputs one ns after each edge.
module tb_door_motion_sequencer;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_UP    = 3'b001;
  localparam logic [2:0] S_DN    = 3'b010;
  localparam logic [2:0] S_DEAD  = 3'b011;
  localparam logic [2:0] S_FAULT = 3'b100;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Wall_Btn, Remote_Btn, UP_Max, DN_Max, Obstruct, Fault_Clr;
  logic       UP_Motor, DN_Motor, Fault;
  logic [2:0] Door_State;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_st;
  logic [5:0] act_v, exp_v;

  door_motion_sequencer #(
    .CNT_W(8), .DEAD_TIME(4), .TRAVEL_TIMEOUT(200), .AUTO_CLOSE_CYCLES(150)
  ) dut (
    .CLK(CLK), .RST(RST), .Wall_Btn(Wall_Btn), .Remote_Btn(Remote_Btn),
    .UP_Max(UP_Max), .DN_Max(DN_Max), .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
    .UP_Motor(UP_Motor), .DN_Motor(DN_Motor), .Fault(Fault), .Door_State(Door_State)
  );

  always #5 CLK = ~CLK;

  // Monitor: one expected entry per clock edge.
  always @(posedge CLK) begin
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      exp_st = exp_q.pop_front();
      exp_v  = {exp_st, exp_st == S_UP, exp_st == S_DN, exp_st == S_FAULT};
      act_v  = {Door_State, UP_Motor, DN_Motor, Fault};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cyc%0d state/up/dn/fault got %b_%b%b%b expected %b_%b%b%b", cyc_no,
                 act_v[5:3], act_v[2], act_v[1], act_v[0], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic cyc(input logic [2:0] st);
    exp_q.push_back(st);
    @(posedge CLK);
    #2;
  endtask

  task automatic run(input int n, input logic [2:0] st);
    for (int i = 0; i < n; i++) cyc(st);
  endtask

  initial begin
    RST = 1'b1; Wall_Btn = 0; Remote_Btn = 0; UP_Max = 0; DN_Max = 0; Obstruct = 0; Fault_Clr = 0;
    run(3, S_IDLE);
    RST = 1'b0;

    // Closed door, wall press opens; open limit stops.
    DN_Max = 1;
    cyc(S_IDLE);
    Wall_Btn = 1; cyc(S_UP);
    Wall_Btn = 0; run(19, S_UP);
    UP_Max = 1; DN_Max = 0; cyc(S_IDLE);
    run(2, S_IDLE);

    // Remote close, obstruction -> 4 dead cycles -> reverse up.
    Remote_Btn = 1; cyc(S_DN);
    Remote_Btn = 0; UP_Max = 0; run(9, S_DN);
    Obstruct = 1; cyc(S_DEAD);
    run(3, S_DEAD);
    cyc(S_UP);

    // Obstruct ignored while rising; watchdog fires 200 edges after entry.
    run(2, S_UP);
    Obstruct = 0; run(197, S_UP);
    cyc(S_FAULT);
    run(2, S_FAULT);
    Fault_Clr = 1; cyc(S_IDLE);
    Fault_Clr = 0; cyc(S_IDLE);
    Wall_Btn = 1; cyc(S_DN);
    Wall_Btn = 0; run(3, S_DN);

    // Both limits during closing -> fault; clear refused while both limits high.
    UP_Max = 1; DN_Max = 1; cyc(S_FAULT);
    Fault_Clr = 1; run(3, S_FAULT);
    UP_Max = 0; cyc(S_IDLE);
    Fault_Clr = 0; cyc(S_IDLE);

    // Long overlapping presses give a single entry; a new press stops travel.
    Wall_Btn = 1; cyc(S_UP);
    run(29, S_UP);
    Remote_Btn = 1; run(20, S_UP);
    DN_Max = 0; Wall_Btn = 0; run(10, S_UP);
    Remote_Btn = 0; run(9, S_UP);
    Remote_Btn = 1; cyc(S_IDLE);
    Remote_Btn = 0; run(2, S_IDLE);

    // Limit on the same edge as the watchdog: limit wins.
    Wall_Btn = 1; cyc(S_DN);
    Wall_Btn = 0; run(199, S_DN);
    DN_Max = 1; cyc(S_IDLE);
    cyc(S_IDLE);
    Obstruct = 1; run(2, S_IDLE);
    Obstruct = 0;

    // Asynchronous reset mid-travel drops the motor before the next edge.
    Wall_Btn = 1; cyc(S_UP);
    Wall_Btn = 0; DN_Max = 0; run(3, S_UP);
    RST = 1'b1;
    #1;
    n_checks++;
    if ({Door_State, UP_Motor, DN_Motor, Fault} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL async_rst got %b_%b%b%b expected 000_000", Door_State, UP_Motor, DN_Motor, Fault);
    end
    run(2, S_IDLE);
    RST = 1'b0;

    UP_Max = 1;
`ifdef DOOR_AUTO_CLOSE_EN
    run(149, S_IDLE);
    cyc(S_DN);
    Wall_Btn = 1; UP_Max = 0; cyc(S_IDLE);
    Wall_Btn = 0; UP_Max = 1;
    run(99, S_IDLE);
    Obstruct = 1; cyc(S_IDLE);
    Obstruct = 0; run(149, S_IDLE);
    cyc(S_DN);
    UP_Max = 0; run(2, S_DN);
`else
    run(160, S_IDLE);
`endif

    repeat (3) @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
